// File: rtl/spi_pkg.sv
// Shared types and helpers for the spi_mem arbiter: bus widths, FSM state
// encoding and the rotating-priority pick function.
package spi_pkg;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWrStrobe,
    StRdWait,
    StResp
  } arb_state_t;

  // First set bit at or above ptr, wrapping. Unused upper bits must be zero, so
  // wrapping mod MAX_REQ yields the same order as wrapping mod NUM_REQ.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    rr_pick = ptr;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: request vector and pointer in, one-hot grant
// and index out. SPI_MEM_ARB_PRIO0_EN gives requester 0 absolute priority.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_idx,
  output logic               any
);

  logic [MAX_REQ-1:0] req_ext;

  assign any = |req;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
`ifdef SPI_MEM_ARB_PRIO0_EN
    // With req[0] low the rotate only ever sees requesters 1..NUM_REQ-1.
    if (req[0]) gnt_idx = 3'd0;
    else        gnt_idx = rr_pick(req_ext, rr_ptr);
`else
    gnt_idx = rr_pick(req_ext, rr_ptr);
`endif
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) gnt[i] = any && (gnt_idx == 3'(i));
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares the single-port spi_mem between NUM_REQ requesters and sequences the memory pins.
// Build option SPI_MEM_ARB_PRIO0_EN: requester 0 (SPI slave) always wins in IDLE.
module spi_mem_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rwb,
  input  logic [NUM_REQ*ADDR_W-1:0] req_add,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [2:0]                gnt_id,
  output logic [ADDR_W-1:0]         mem_add,
  output logic [DATA_W-1:0]         mem_data_in,
  output logic                      mem_rwb,
  input  logic [DATA_W-1:0]         mem_data_out
);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_oh_q, gnt_oh_d, ack_q, ack_d, win_oh;
  logic [2:0]          gnt_id_q, gnt_id_d, rr_ptr_q, rr_ptr_d, win_idx, ptr_inc;
  logic [ADDR_W-1:0]   mem_add_q, mem_add_d, win_add;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, win_wdata;
  logic                rd_q, rd_d, mem_rwb_q, mem_rwb_d, win_rd, win_any;
  logic [1:0]          cnt_q, cnt_d;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (win_oh),
    .gnt_idx(win_idx),
    .any    (win_any)
  );

  always_comb begin
    win_add   = '0;
    win_wdata = '0;
    win_rd    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_add   |= req_add[i*ADDR_W +: ADDR_W];
        win_wdata |= req_wdata[i*DATA_W +: DATA_W];
        win_rd    |= req_rwb[i];
      end
    end
  end

  assign ptr_inc = (gnt_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_id_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    gnt_oh_d  = gnt_oh_q;
    gnt_id_d  = gnt_id_q;
    rr_ptr_d  = rr_ptr_q;
    mem_add_d = mem_add_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    mem_rwb_d = mem_rwb_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          gnt_oh_d  = win_oh;
          gnt_id_d  = win_idx;
          mem_add_d = win_add;
          wdata_d   = win_wdata;
          rd_d      = win_rd;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (rd_q) begin
          cnt_d   = 2'(MEM_RD_LAT - 1);
          state_d = StRdWait;
        end else begin
          mem_rwb_d = 1'b0;
          state_d   = StWrStrobe;
        end
      end
      StWrStrobe: begin
        mem_rwb_d = 1'b1;
        ack_d     = gnt_oh_q;
        state_d   = StResp;
      end
      StRdWait: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_data_out;
          ack_d   = gnt_oh_q;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
`ifdef SPI_MEM_ARB_PRIO0_EN
        if (gnt_id_q != 3'd0) rr_ptr_d = ptr_inc;
`else
        rr_ptr_d = ptr_inc;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      gnt_oh_q  <= '0;
      gnt_id_q  <= 3'd0;
      rr_ptr_q  <= 3'd0;
      mem_add_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_q      <= 1'b0;
      mem_rwb_q <= 1'b1;
      cnt_q     <= 2'd0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_oh_q  <= gnt_oh_d;
      gnt_id_q  <= gnt_id_d;
      rr_ptr_q  <= rr_ptr_d;
      mem_add_q <= mem_add_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      mem_rwb_q <= mem_rwb_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != StIdle);
  assign gnt_id      = gnt_id_q;
  assign mem_add     = mem_add_q;
  assign mem_data_in = wdata_q;
  assign mem_rwb     = mem_rwb_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: three instances (NUM_REQ=3, read latency 1/2/3), each with
// its own memory model, driven from a vector table plus hand-written corner sequences.
module tb_spi_mem_arbiter;

  localparam int NR = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    req         [3];
  logic [NR-1:0]    req_rwb     [3];
  logic [NR*7-1:0]  req_add     [3];
  logic [NR*16-1:0] req_wdata   [3];
  logic [NR-1:0]    ack         [3];
  logic [15:0]      rdata       [3];
  logic             busy        [3];
  logic [2:0]       gnt_id      [3];
  logic [6:0]       mem_add     [3];
  logic [15:0]      mem_data_in [3];
  logic             mem_rwb     [3];
  logic [15:0]      mem_data_out[3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [15:0] mem  [128];
    logic [15:0] pipe [3];

    spi_mem_arbiter #(
      .NUM_REQ   (NR),
      .MEM_RD_LAT(g + 1)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req[g]),
      .req_rwb     (req_rwb[g]),
      .req_add     (req_add[g]),
      .req_wdata   (req_wdata[g]),
      .ack         (ack[g]),
      .rdata       (rdata[g]),
      .busy        (busy[g]),
      .gnt_id      (gnt_id[g]),
      .mem_add     (mem_add[g]),
      .mem_data_in (mem_data_in[g]),
      .mem_rwb     (mem_rwb[g]),
      .mem_data_out(mem_data_out[g])
    );

    initial for (int a = 0; a < 128; a++) mem[a] = 16'hA000 + 16'(a);

    always @(posedge clk) begin
      if (!mem_rwb[g]) mem[mem_add[g]] <= mem_data_in[g];
      pipe[0] <= mem[mem_add[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_data_out[g] = pipe[g];
  end

  typedef struct {
    int          k;
    int          r;
    bit          rd;
    logic [6:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with instance k idle; returns at a negedge with it idle again.
  task automatic txn(input int k, input int r, input bit rd, input logic [6:0] addr,
                     input logic [15:0] wdata, input int exp_lat, input logic [15:0] exp_rdata,
                     input bit chg, input string tag);
    int c;
    int lows;
    bit got;
    req_rwb[k][r]           = rd;
    req_add[k][r*7 +: 7]    = addr;
    req_wdata[k][r*16 +: 16] = wdata;
    req[k][r]               = 1'b1;
    @(posedge clk);
    c = 0;
    lows = 0;
    got = 1'b0;
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      if (chg && c == 1) begin
        req_wdata[k][r*16 +: 16] = wdata ^ 16'h3333;
        req_add[k][r*7 +: 7]     = addr ^ 7'h01;
      end
      if (!mem_rwb[k]) lows++;
      if (ack[k] != '0) got = 1'b1;
    end
    chk({tag, " latency"}, 32'(got ? c : 99), 32'(exp_lat));
    chk({tag, " ack"}, 32'(ack[k]), 32'(1 << r));
    chk({tag, " gnt_id"}, 32'(gnt_id[k]), 32'(r));
    chk({tag, " busy"}, 32'(busy[k]), 32'd1);
    chk({tag, " rdata"}, 32'(rdata[k]), 32'(exp_rdata));
    chk({tag, " rwb_low"}, 32'(lows), 32'(rd ? 0 : 1));
    req[k][r] = 1'b0;
    @(negedge clk);
    chk({tag, " ack_clear"}, 32'(ack[k]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    int acks;
    int e;

    vecs[0]  = '{0, 0, 1'b0, 7'h12, 16'hBEEF, 3, 16'h0000};
    vecs[1]  = '{0, 0, 1'b1, 7'h12, 16'h0000, 3, 16'hBEEF};
    vecs[2]  = '{0, 2, 1'b1, 7'h33, 16'h0000, 3, 16'hA033};
    vecs[3]  = '{0, 1, 1'b0, 7'h12, 16'h5555, 3, 16'hA033};
    vecs[4]  = '{0, 2, 1'b1, 7'h12, 16'h0000, 3, 16'h5555};
    vecs[5]  = '{1, 1, 1'b0, 7'h40, 16'hCAFE, 3, 16'h0000};
    vecs[6]  = '{1, 1, 1'b1, 7'h40, 16'h0000, 4, 16'hCAFE};
    vecs[7]  = '{1, 2, 1'b1, 7'h7F, 16'h0000, 4, 16'hA07F};
    vecs[8]  = '{2, 2, 1'b0, 7'h41, 16'h1234, 3, 16'h0000};
    vecs[9]  = '{2, 0, 1'b1, 7'h41, 16'h0000, 5, 16'h1234};
    vecs[10] = '{2, 1, 1'b1, 7'h10, 16'h0000, 5, 16'hA010};

    for (int k = 0; k < 3; k++) begin
      req[k] = '0;
      req_rwb[k] = '0;
      req_add[k] = '0;
      req_wdata[k] = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset ack%0d", k), 32'(ack[k]), 32'd0);
      chk($sformatf("reset rdata%0d", k), 32'(rdata[k]), 32'd0);
      chk($sformatf("reset busy%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("reset gnt_id%0d", k), 32'(gnt_id[k]), 32'd0);
      chk($sformatf("reset mem_add%0d", k), 32'(mem_add[k]), 32'd0);
      chk($sformatf("reset mem_data_in%0d", k), 32'(mem_data_in[k]), 32'd0);
      chk($sformatf("reset mem_rwb%0d", k), 32'(mem_rwb[k]), 32'd1);
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].k, vecs[i].r, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
          vecs[i].exp_rdata, 1'b0, $sformatf("vec%0d", i));
    end

    // Payload (data and address) altered during ISSUE must not leak into the memory.
    txn(0, 1, 1'b0, 7'h05, 16'h1111, 3, 16'h5555, 1'b1, "payload_wr");
    txn(0, 2, 1'b1, 7'h05, 16'h0000, 3, 16'h1111, 1'b0, "payload_rd");
    chk("payload mem05", 32'(g_dut[0].mem[5]), 32'h1111);
    chk("payload mem04", 32'(g_dut[0].mem[4]), 32'hA004);

    // Reset while a write sits in ISSUE.
    req_rwb[0][0]      = 1'b0;
    req_add[0][6:0]    = 7'h20;
    req_wdata[0][15:0] = 16'hDEAD;
    req[0][0]          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid busy_before", 32'(busy[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid ack", 32'(ack[0]), 32'd0);
    chk("rst_mid busy", 32'(busy[0]), 32'd0);
    chk("rst_mid mem_rwb", 32'(mem_rwb[0]), 32'd1);
    chk("rst_mid mem_add", 32'(mem_add[0]), 32'd0);
    chk("rst_mid rdata", 32'(rdata[0]), 32'd0);
    chk("rst_mid gnt_id", 32'(gnt_id[0]), 32'd0);
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack[0] != '0) acks++;
    end
    req[0][0] = 1'b0;
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ack[0] != '0 || !mem_rwb[0]) acks++;
    end
    chk("rst_mid no_ack", 32'(acks), 32'd0);
    chk("rst_mid mem20", 32'(g_dut[0].mem[7'h20]), 32'hA020);

`ifdef SPI_MEM_ARB_PRIO0_EN
    // Requesters 0 and 1 both held: 0 wins until it drops, then 1.
    for (int r = 0; r < 2; r++) begin
      req_rwb[0][r] = 1'b1;
      req_add[0][r*7 +: 7] = 7'(r + 1);
    end
    req[0][1:0] = 2'b11;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack[0] != '0) begin
        e = (n < 4) ? 0 : 1;
        chk($sformatf("prio gnt%0d", n), 32'(gnt_id[0]), 32'(e));
        chk($sformatf("prio ack%0d", n), 32'(ack[0]), 32'(1 << e));
        if (n == 3) req[0][0] = 1'b0;
        n++;
      end
    end
    chk("prio grants", 32'(n), 32'd6);
`else
    // All three requesters held high doing reads: strict rotation from pointer 0.
    for (int r = 0; r < NR; r++) begin
      req_rwb[0][r] = 1'b1;
      req_add[0][r*7 +: 7] = 7'(r + 1);
    end
    req[0] = '1;
    n = 0;
    cyc = 0;
    while (n < 9 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack[0] != '0) begin
        e = n % 3;
        chk($sformatf("rr gnt%0d", n), 32'(gnt_id[0]), 32'(e));
        chk($sformatf("rr ack%0d", n), 32'(ack[0]), 32'(1 << e));
        chk($sformatf("rr rdata%0d", n), 32'(rdata[0]), 32'(16'hA001 + 16'(e)));
        n++;
      end
    end
    chk("rr grants", 32'(n), 32'd9);
`endif
    req[0] = '0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
